// File: rtl/usb_pkg.sv
// Shared USB definitions: packet IDs from usb_rx / to usb_tx, the protocol
// controller state encoding, and common constants.
package usb_pkg;

    localparam int unsigned USB_MAX_PKT = 64;

    typedef enum logic [2:0] {
        RX_NONE  = 3'd0,
        RX_OUT   = 3'd1,
        RX_IN    = 3'd2,
        RX_DATA0 = 3'd3,
        RX_DATA1 = 3'd4,
        RX_ACK   = 3'd5,
        RX_NAK   = 3'd6,
        RX_BAD   = 3'd7
    } rx_pid_t;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4
    } tx_pid_t;

    typedef enum logic [2:0] {
        IDLE,
        OUT_WAIT,
        SEND_HS,
        SEND_DATA,
        TX_WAIT,
        ACK_WAIT
    } ctrl_state_t;

    // DATA PID to transmit for a given data toggle (0 = DATA0).
    function automatic tx_pid_t data_pid(input logic toggle);
        return toggle ? TX_DATA1 : TX_DATA0;
    endfunction

    function automatic logic is_data(input rx_pid_t pid);
        return (pid == RX_DATA0) || (pid == RX_DATA1);
    endfunction

endpackage

// File: rtl/usb_timeout_counter.sv
// Clear/enable counter that wraps at LIMIT and flags the terminal count.
module usb_timeout_counter #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // Count while enabled, restart from zero on clear or at the terminal value.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/usb_protocol_ctrl.sv
// Transaction sequencer between usb_rx, usb_tx and the endpoint buffer:
// chooses handshake/data responses, tracks DATA0/1 toggles, owns bus direction.
module usb_protocol_ctrl
    import usb_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] rx_packet,
    input  logic       rx_done,
    input  logic       rx_err,
    input  logic       tx_done,
    input  logic       tx_data_pending,
    input  logic       rx_data_read,
    output logic [2:0] tx_packet,
    output logic       tx_start,
    output logic       d_mode,
    output logic       clear_buffer,
    output logic       rx_data_ready,
    output logic       tx_ack,
    output logic       tx_error,
    output logic       rx_error
);

    ctrl_state_t state, state_n;
    tx_pid_t     pkt_q, pkt_n;
    rx_pid_t     pid;

    logic rx_ok;
    logic start_n, dmode_n, clr_n, tack_n, terr_n, rerr_n;
    logic set_ready;
    logic rx_tog, rx_tog_n;
    logic tx_tog, tx_tog_n;
    logic nak_pend, nak_pend_n;
    logic tmr_clear, tmr_en, tmr_expired;

    assign pid       = rx_pid_t'(rx_packet);
    // Packets seen while we drive the bus are our own echo; ignore them.
    assign rx_ok     = rx_done && !d_mode;
    assign tx_packet = pkt_q;

    assign tmr_en    = (state == OUT_WAIT) || (state == ACK_WAIT);
    assign tmr_clear = !tmr_en;

    usb_timeout_counter #(
        .LIMIT(ACK_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expired(tmr_expired)
    );

    // Next-state and next-output decode; tx_start/tx_packet/d_mode are loaded
    // on the transition into SEND_*, so they appear in the SEND_* cycle itself.
    always_comb begin
        state_n    = state;
        pkt_n      = pkt_q;
        start_n    = 1'b0;
        dmode_n    = d_mode;
        clr_n      = 1'b0;
        tack_n     = 1'b0;
        terr_n     = 1'b0;
        rerr_n     = 1'b0;
        set_ready  = 1'b0;
        rx_tog_n   = rx_tog;
        tx_tog_n   = tx_tog;
        nak_pend_n = nak_pend;

        case (state)
            IDLE: begin
                if (rx_ok && !rx_err) begin
                    if (pid == RX_OUT) begin
                        state_n    = OUT_WAIT;
                        nak_pend_n = rx_data_ready;
                    end else if (pid == RX_IN) begin
                        start_n = 1'b1;
                        dmode_n = 1'b1;
                        if (tx_data_pending) begin
                            state_n = SEND_DATA;
                            pkt_n   = data_pid(tx_tog);
                        end else begin
                            state_n = SEND_HS;
                            pkt_n   = TX_NAK;
                        end
                    end
                end
            end

            OUT_WAIT: begin
                if (rx_ok) begin
                    if (rx_err || !is_data(pid)) begin
                        rerr_n  = 1'b1;
                        clr_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = SEND_HS;
                        start_n = 1'b1;
                        dmode_n = 1'b1;
                        if (nak_pend) begin
                            clr_n = 1'b1;
                            pkt_n = TX_NAK;
                        end else if ((pid == RX_DATA1) == rx_tog) begin
                            pkt_n     = TX_ACK;
                            set_ready = 1'b1;
                            rx_tog_n  = !rx_tog;
                        end else begin
                            clr_n = 1'b1;
                            pkt_n = TX_ACK;
                        end
                    end
                end else if (tmr_expired) begin
                    rerr_n  = 1'b1;
                    clr_n   = 1'b1;
                    state_n = IDLE;
                end
            end

            SEND_HS, SEND_DATA: begin
                state_n = TX_WAIT;
            end

            TX_WAIT: begin
                if (tx_done) begin
                    pkt_n   = TX_NONE;
                    dmode_n = 1'b0;
                    state_n = ((pkt_q == TX_DATA0) || (pkt_q == TX_DATA1)) ? ACK_WAIT : IDLE;
                end
            end

            ACK_WAIT: begin
                if (rx_ok) begin
                    state_n = IDLE;
                    if ((pid == RX_ACK) && !rx_err) begin
                        tack_n   = 1'b1;
                        tx_tog_n = !tx_tog;
                    end else begin
                        terr_n = 1'b1;
                    end
                end else if (tmr_expired) begin
                    terr_n  = 1'b1;
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State, toggles and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            pkt_q        <= TX_NONE;
            tx_start     <= 1'b0;
            d_mode       <= 1'b0;
            clear_buffer <= 1'b0;
            tx_ack       <= 1'b0;
            tx_error     <= 1'b0;
            rx_error     <= 1'b0;
            rx_tog       <= 1'b0;
            tx_tog       <= 1'b0;
            nak_pend     <= 1'b0;
        end else begin
            state        <= state_n;
            pkt_q        <= pkt_n;
            tx_start     <= start_n;
            d_mode       <= dmode_n;
            clear_buffer <= clr_n;
            tx_ack       <= tack_n;
            tx_error     <= terr_n;
            rx_error     <= rerr_n;
            rx_tog       <= rx_tog_n;
            tx_tog       <= tx_tog_n;
            nak_pend     <= nak_pend_n;
        end
    end

    // Sticky "OUT data waiting" flag; a same-cycle set beats the read clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_ready <= 1'b0;
        end else if (set_ready) begin
            rx_data_ready <= 1'b1;
        end else if (rx_data_read) begin
            rx_data_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_protocol_ctrl.sv
// Scoreboard bench for usb_protocol_ctrl: transaction tasks predict each
// output event from the protocol rules; a forked monitor checks them.
module tb_usb_protocol_ctrl;

    localparam logic [2:0] P_OUT = 3'd1, P_IN = 3'd2, P_D0 = 3'd3, P_D1 = 3'd4;
    localparam logic [2:0] P_ACK = 3'd5, P_NAK = 3'd6, P_BAD = 3'd7;
    localparam logic [2:0] T_NONE = 3'd0, T_D0 = 3'd1, T_D1 = 3'd2, T_ACK = 3'd3, T_NAK = 3'd4;
    localparam int unsigned TO = 1024;

    localparam int R_ACK = 0, R_BAD = 1, R_TIMEOUT = 2;
    localparam int K_DATA = 0, K_ERR = 1, K_BADPID = 2, K_OTHER = 3, K_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] rx_packet = '0;
    logic       rx_done = 1'b0, rx_err = 1'b0, tx_done = 1'b0;
    logic       tx_data_pending = 1'b0, rx_data_read = 1'b0;
    logic [2:0] tx_packet;
    logic       tx_start, d_mode, clear_buffer, rx_data_ready, tx_ack, tx_error, rx_error;

    usb_protocol_ctrl #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_done(rx_done),
        .rx_err(rx_err), .tx_done(tx_done), .tx_data_pending(tx_data_pending),
        .rx_data_read(rx_data_read), .tx_packet(tx_packet), .tx_start(tx_start),
        .d_mode(d_mode), .clear_buffer(clear_buffer), .rx_data_ready(rx_data_ready),
        .tx_ack(tx_ack), .tx_error(tx_error), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        start;
        logic [2:0]  pkt;
        logic        clr;
        logic        ack;
        logic        terr;
        logic        rerr;
        int unsigned at;
        int unsigned slack;
    } ev_t;

    ev_t sb[$];
    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: host-visible protocol state only.
    logic m_tx_tog = 1'b0, m_rx_tog = 1'b0, m_ready = 1'b0;
    int unsigned n_timeouts = 0;

    task automatic push_ev(input logic s, input logic [2:0] p, input logic c, input logic a,
                           input logic te, input logic re, input int unsigned at, input int unsigned sl);
        ev_t e;
        e.start = s; e.pkt = p; e.clr = c; e.ack = a; e.terr = te; e.rerr = re;
        e.at = at; e.slack = sl;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        ev_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (n_rst && (tx_start || clear_buffer || tx_ack || tx_error || rx_error)) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got start=%0b pkt=%0d clr=%0b ack=%0b terr=%0b rerr=%0b at cycle %0d, expected no event",
                             tx_start, tx_packet, clear_buffer, tx_ack, tx_error, rx_error, cyc);
                end else begin
                    e = sb.pop_front();
                    ok = (tx_start == e.start) && (clear_buffer == e.clr) && (tx_ack == e.ack) &&
                         (tx_error == e.terr) && (rx_error == e.rerr) &&
                         (!e.start || (tx_packet == e.pkt)) &&
                         (cyc >= e.at) && (cyc <= e.at + e.slack);
                    if (!ok) begin
                        errors++;
                        $display("FAIL event: got start=%0b pkt=%0d clr=%0b ack=%0b terr=%0b rerr=%0b cycle=%0d, expected start=%0b pkt=%0d clr=%0b ack=%0b terr=%0b rerr=%0b cycle=%0d..%0d",
                                 tx_start, tx_packet, clear_buffer, tx_ack, tx_error, rx_error, cyc,
                                 e.start, e.pkt, e.clr, e.ack, e.terr, e.rerr, e.at, e.at + e.slack);
                    end
                end
            end
        end
    endtask

    task automatic idle(input int unsigned n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // One-cycle rx_done; 'at' is the cycle the packet is presented.
    task automatic send_pkt(input logic [2:0] p, input logic err, output int unsigned at);
        @(posedge clk); #1;
        rx_packet = p; rx_done = 1'b1; rx_err = err; at = cyc;
        @(posedge clk); #1;
        rx_packet = '0; rx_done = 1'b0; rx_err = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_output: %0d expected events never appeared (cycle %0d)", sb.size(), cyc);
            sb.delete();
        end
        idle(2);
    endtask

    // Plays usb_tx: lets the packet run, optionally echoes a packet while
    // the bus is ours, then finishes with tx_done. T = tx_done cycle.
    task automatic finish_tx(input logic [2:0] exp_pkt, output int unsigned T);
        int unsigned dummy;
        idle($urandom_range(1, 4));
        if ($urandom_range(0, 2) == 0) send_pkt(P_IN, 1'b0, dummy);
        @(posedge clk); #1;
        chk("d_mode_busy", {7'd0, d_mode}, 8'd1);
        chk("tx_packet_hold", {5'd0, tx_packet}, {5'd0, exp_pkt});
        tx_done = 1'b1; T = cyc;
        @(posedge clk); #1;
        tx_done = 1'b0;
        chk("d_mode_release", {7'd0, d_mode}, 8'd0);
        chk("tx_packet_none", {5'd0, tx_packet}, {5'd0, T_NONE});
    endtask

    task automatic in_txn(input logic pending, input int resp);
        int unsigned at, at2, T;
        logic [2:0] exp;
        tx_data_pending = pending;
        send_pkt(P_IN, 1'b0, at);
        exp = pending ? (m_tx_tog ? T_D1 : T_D0) : T_NAK;
        push_ev(1, exp, 0, 0, 0, 0, at + 1, 0);
        finish_tx(exp, T);
        if (pending) begin
            if (resp == R_ACK) begin
                idle($urandom_range(0, 3));
                send_pkt(P_ACK, 1'b0, at2);
                push_ev(0, 0, 0, 1, 0, 0, at2 + 1, 0);
                m_tx_tog = !m_tx_tog;
            end else if (resp == R_BAD) begin
                idle($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) send_pkt(P_ACK, 1'b1, at2);
                else                           send_pkt(P_NAK, 1'b0, at2);
                push_ev(0, 0, 0, 0, 1, 0, at2 + 1, 0);
            end else begin
                push_ev(0, 0, 0, 0, 1, 0, T + 1 + TO - 1, 1);
                n_timeouts++;
            end
        end
        drain();
    endtask

    task automatic out_txn(input int kind, input logic [2:0] dpid);
        int unsigned at, T;
        logic nakp;
        logic tx_exp;
        logic [2:0] exp;
        logic [2:0] other_pids [4];
        other_pids[0] = P_OUT; other_pids[1] = P_IN; other_pids[2] = P_ACK; other_pids[3] = P_NAK;
        tx_exp = 1'b0;
        exp = T_NONE;
        send_pkt(P_OUT, 1'b0, at);
        nakp = m_ready;
        if (kind == K_TIMEOUT) begin
            push_ev(0, 0, 1, 0, 0, 1, at + 1 + TO - 1, 1);
            n_timeouts++;
        end else begin
            idle($urandom_range(0, 3));
            if (kind == K_DATA) begin
                send_pkt(dpid, 1'b0, at);
                tx_exp = 1'b1;
                if (nakp) begin
                    exp = T_NAK;
                    push_ev(1, exp, 1, 0, 0, 0, at + 1, 0);
                end else if ((dpid == P_D1) == m_rx_tog) begin
                    exp = T_ACK;
                    push_ev(1, exp, 0, 0, 0, 0, at + 1, 0);
                    m_ready = 1'b1;
                    m_rx_tog = !m_rx_tog;
                end else begin
                    exp = T_ACK;
                    push_ev(1, exp, 1, 0, 0, 0, at + 1, 0);
                end
            end else begin
                if (kind == K_ERR)         send_pkt(dpid, 1'b1, at);
                else if (kind == K_BADPID) send_pkt(P_BAD, 1'b0, at);
                else                       send_pkt(other_pids[$urandom_range(0, 3)], 1'b0, at);
                push_ev(0, 0, 1, 0, 0, 1, at + 1, 0);
            end
        end
        if (tx_exp) finish_tx(exp, T);
        drain();
        chk("rx_data_ready", {7'd0, rx_data_ready}, {7'd0, m_ready});
    endtask

    task automatic read_pulse();
        @(posedge clk); #1;
        rx_data_read = 1'b1;
        @(posedge clk); #1;
        rx_data_read = 1'b0;
        m_ready = 1'b0;
        chk("ready_cleared", {7'd0, rx_data_ready}, 8'd0);
    endtask

    // Packets the controller must not respond to while idle.
    task automatic ignored_pkt();
        int unsigned at;
        logic [2:0] p;
        logic [2:0] junk [5];
        junk[0] = P_D0; junk[1] = P_D1; junk[2] = P_ACK; junk[3] = P_NAK; junk[4] = P_BAD;
        if ($urandom_range(0, 1) == 0) begin
            p = junk[$urandom_range(0, 4)];
            send_pkt(p, 1'b0, at);
        end else begin
            p = ($urandom_range(0, 1) == 0) ? P_IN : P_OUT;
            send_pkt(p, 1'b1, at);
        end
        idle(3);
    endtask

    function automatic logic [7:0] outs_packed();
        return {tx_packet, tx_start, d_mode, clear_buffer, rx_data_ready, tx_ack | tx_error | rx_error};
    endfunction

    initial begin
        int unsigned at;
        int k;
        fork
            monitor();
        join_none

        idle(3);
        chk("reset_outputs", outs_packed(), 8'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        idle(2);

        // IN with data, host ACKs; second IN must carry DATA1.
        in_txn(1'b1, R_ACK);
        in_txn(1'b1, R_ACK);
        // IN without data -> NAK, toggle untouched.
        in_txn(1'b0, R_ACK);
        in_txn(1'b1, R_ACK);

        // OUT/DATA0 accepted, repeat without read -> NAK, read, OUT/DATA1 accepted.
        out_txn(K_DATA, P_D0);
        out_txn(K_DATA, P_D0);
        read_pulse();
        out_txn(K_DATA, P_D1);
        read_pulse();
        // Corrupted DATA0 -> rx_error/clear_buffer, no handshake.
        out_txn(K_ERR, P_D0);
        // Host retry of already-accepted DATA1 -> ACK with buffer discard.
        out_txn(K_DATA, P_D1);

        // No host ACK: timeout, then retry carries the same toggle.
        in_txn(1'b1, R_TIMEOUT);
        in_txn(1'b1, R_ACK);
        out_txn(K_TIMEOUT, P_D0);

        // Asynchronous reset while usb_tx is busy.
        tx_data_pending = 1'b1;
        send_pkt(P_IN, 1'b0, at);
        push_ev(1, m_tx_tog ? T_D1 : T_D0, 0, 0, 0, 0, at + 1, 0);
        @(posedge clk); #3;
        n_rst = 1'b0;
        #1;
        chk("async_reset_outputs", outs_packed(), 8'd0);
        chk("async_reset_tx_packet", {5'd0, tx_packet}, 8'd0);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL reset_pending_events: got %0d queued expected 0", sb.size());
            sb.delete();
        end
        m_tx_tog = 1'b0; m_rx_tog = 1'b0; m_ready = 1'b0;
        idle(2);
        n_rst = 1'b1;
        idle(6);
        in_txn(1'b1, R_ACK);

        // Randomised traffic.
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 11));
            case (k)
                0, 1, 2: in_txn(1'b1, ($urandom_range(0, 3) == 0) ? R_BAD : R_ACK);
                3:       in_txn(1'b0, R_ACK);
                4, 5, 6: out_txn(K_DATA, ($urandom_range(0, 1) == 0) ? P_D0 : P_D1);
                7:       out_txn(($urandom_range(0, 1) == 0) ? K_ERR : (($urandom_range(0, 1) == 0) ? K_BADPID : K_OTHER),
                                 ($urandom_range(0, 1) == 0) ? P_D0 : P_D1);
                8:       read_pulse();
                9:       ignored_pkt();
                default: begin
                    if (n_timeouts < 4) begin
                        if ($urandom_range(0, 1) == 0) in_txn(1'b1, R_TIMEOUT);
                        else                           out_txn(K_TIMEOUT, P_D0);
                    end else begin
                        in_txn(1'b1, R_ACK);
                    end
                end
            endcase
        end

        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_protocol_ctrl.md
# usb_protocol_ctrl

Transaction-level sequencer between `usb_rx`, `usb_tx` and the shared endpoint data buffer in the USB-AHB module. It consumes decoded packet events from `usb_rx`, decides the handshake or data response, starts `usb_tx`, and owns the D+/D- direction. It also tracks the DATA0/DATA1 toggles and exposes buffer-ownership status to the AHB slave side.

## Interface
- `ACK_TIMEOUT`, default 1024: cycles to wait for a follow-on packet (DATA after OUT, or ACK after our DATA) before abandoning the transaction.
- `clk`  in  1  system clock; all logic on rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `rx_packet`  in  3  PID from `usb_rx`, decoded per `usb_pkg::rx_pid_t`: 0 NONE, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 BAD. Valid when `rx_done`=1.
- `rx_done`  in  1  one-cycle pulse at EOP of a received packet.
- `rx_err`  in  1  one-cycle pulse, coincident with `rx_done`, flagging a CRC or stuffing error.
- `tx_done`  in  1  one-cycle pulse when `usb_tx` finishes EOP.
- `tx_data_pending`  in  1  level; the AHB side has loaded IN data into the buffer.
- `rx_data_read`  in  1  one-cycle pulse; the AHB side has drained the OUT data.
- `tx_packet`  out  3  `usb_pkg::tx_pid_t`: 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK.
- `tx_start`  out  1  one-cycle pulse that starts `usb_tx`.
- `d_mode`  out  1  1 while this block drives the bus.
- `clear_buffer`  out  1  one-cycle pulse that discards buffer contents.
- `rx_data_ready`  out  1  sticky; valid OUT data is waiting in the buffer.
- `tx_ack`  out  1  one-cycle pulse when the host ACKs our DATA.
- `tx_error`  out  1  one-cycle pulse on IN transaction failure.
- `rx_error`  out  1  one-cycle pulse on OUT transaction failure.

## Operation
- States:
  - IDLE
  - OUT_WAIT: waiting for the DATA packet after an OUT token.
  - SEND_HS: start ACK or NAK.
  - SEND_DATA: start DATA0/1.
  - TX_WAIT: `usb_tx` is busy.
  - ACK_WAIT: waiting for the host's ACK.
- Reset: state IDLE, both toggles DATA0, timer 0, all outputs 0.
- IDLE:
  - `rx_done`&&OUT&&!`rx_err`: go to OUT_WAIT. Latch `nak_pending` = `rx_data_ready`.
  - `rx_done`&&IN&&!`rx_err`: go to SEND_DATA if `tx_data_pending`, otherwise go to SEND_HS with NAK.
  - Any other `rx_done`: ignored.
- OUT_WAIT, on `rx_done`:
  - `rx_err` or BAD: pulse `rx_error` and `clear_buffer`, no handshake, go to IDLE.
  - DATA0/1 with `nak_pending`: pulse `clear_buffer`, send NAK.
  - DATA0/1 whose PID equals `rx_toggle`: send ACK, set `rx_data_ready`, flip `rx_toggle`.
  - DATA0/1 whose PID differs from `rx_toggle` (host retry): send ACK, pulse `clear_buffer`, toggle unchanged.
  - Any other PID, or timer expiry: pulse `rx_error` and `clear_buffer`, go to IDLE.
- SEND_HS and SEND_DATA:
  - Drive `tx_start`=1 for one cycle and `d_mode`=1, then go to TX_WAIT.
  - SEND_DATA sends DATA0 or DATA1 according to `tx_toggle`.
- TX_WAIT, on `tx_done`:
  - After a handshake: go to IDLE.
  - After DATA: go to ACK_WAIT with the timer cleared.
- ACK_WAIT:
  - `rx_done`&&ACK&&!`rx_err`: pulse `tx_ack`, flip `tx_toggle`, go to IDLE.
  - Any other `rx_done`, or timer expiry: pulse `tx_error`, go to IDLE with the toggle unchanged so the host can retry.
- `rx_data_ready`:
  - Set on accepted DATA, cleared by `rx_data_read`.
  - If set and clear occur in the same cycle, set wins.
- `rx_done` pulses while `d_mode`=1 are ignored.

## Timing
- `rx_done` in cycle N → state registered at N+1. `tx_start` asserts at N+1 for IN→NAK/DATA; for OUT it asserts one cycle after the DATA packet's `rx_done`.
- `tx_packet` is registered, valid in the `tx_start` cycle, and held until the cycle after `tx_done`, then returns to NONE.
- `d_mode` rises with `tx_start` and falls in the cycle after `tx_done`.
- Timer:
  - Counts only in OUT_WAIT and ACK_WAIT, and is cleared on entry to either.
  - Expiry is the cycle the count reaches `ACK_TIMEOUT`-1. Expiry has priority below a same-cycle `rx_done`.
  - Width is `$clog2(ACK_TIMEOUT)`.
- All pulse outputs are registered and one cycle wide.
- `n_rst` mid-transaction aborts immediately. No `tx_start` is issued after reset release without a new token.

## Structure
- `usb_pkg`: `rx_pid_t` and `tx_pid_t` enums (encodings above), the state enum, and the `USB_MAX_PKT`=64 constant, shared with `usb_rx` and `usb_tx`.
- Sub-module `usb_timeout_counter`: clear/enable counter with a parameterised rollover value and a one-cycle `expired` output. Everything else lives in one FSM plus toggle and flag registers.

## Test plan
- IN token with `tx_data_pending`=1, then `tx_done`, then ACK → `tx_packet`=1 (DATA0) with `tx_start` at N+1, then `tx_ack` pulse. A second IN sends `tx_packet`=2 (DATA1).
- IN token with `tx_data_pending`=0 → `tx_packet`=4 (NAK), `d_mode` high until `tx_done`+1, toggle unchanged.
- OUT then DATA0 (no error) → ACK sent, `rx_data_ready`=1. Repeat DATA0 without `rx_data_read` → NAK with `clear_buffer` pulse. After `rx_data_read`, OUT then DATA1 → ACK.
- OUT then DATA0 with `rx_err`=1 → `rx_error` and `clear_buffer` pulses, no `tx_start`, state IDLE.
- IN with data, `tx_done`, no host response for `ACK_TIMEOUT` cycles → `tx_error` at cycle 1023 after entering ACK_WAIT. Retry IN still sends DATA0.
- Assert `n_rst` low in TX_WAIT → all outputs 0 asynchronously. After release an IN with pending data sends DATA0.
